// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_pkg
//  Purpose  : Shared definitions for the register bank and its write
//             sequencer: widths, address map, sequencer states and the
//             writable-address decode used by both sides of the port.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package regbank_pkg;

  localparam int RB_DATA_W   = 16;
  localparam int RB_SEL_W    = 6;
  localparam int RB_NUM_GP   = 28;  // general-purpose registers at 0..27
  localparam int RB_PI0_ADDR = 28;  // input port 0 (read-only)
  localparam int RB_PI1_ADDR = 29;  // input port 1 (read-only)
  localparam int RB_PO0_ADDR = 30;
  localparam int RB_PO1_ADDR = 31;
  localparam int RB_W_ADDR   = 34;  // working register, target of memory loads

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // True for every address the bank actually stores.
  function automatic logic is_writable(input logic [RB_SEL_W-1:0] sel);
    return (sel < RB_SEL_W'(RB_NUM_GP))
        || (sel == RB_SEL_W'(RB_PO0_ADDR))
        || (sel == RB_SEL_W'(RB_PO1_ADDR))
        || (sel == RB_SEL_W'(RB_W_ADDR));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-requester round-robin arbiter. The pointer moves to the
//             other requester after every grant, so a requester that keeps
//             asking alternates with the other one.
//  Ports    : clk, reset (sync, active-high)
//             en        - arbitration allowed this cycle
//             req[1:0]  - requests (bit 0 favoured out of reset)
//             grant[1:0]- one-hot or zero grant, combinational
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;  // 0: requester 0 has priority, 1: requester 1 has priority

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0] && (!ptr || !req[1])) begin
        grant[0] = 1'b1;
      end else if (req[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regbank_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_write_sequencer
//  Purpose  : Sole owner of the register bank write port. Sweeps zeros into
//             every writable register after reset or init_start, then
//             arbitrates debug (fixed priority) and ALU/memory (round-robin)
//             writes onto one registered write port, dropping and reporting
//             writes to read-only addresses.
//  Ports    : clk, reset (sync, active-high), init_start
//             dbg_*  / alu_* / mem_*  valid-ready write requesters
//             wr_en, wr_sel, wr_data  registered bank write port
//             busy                    clear sweep in progress
//             err_illegal, err_sel    rejected-write report
//             wr_count                saturating legal write counter
//  Revision : 1.0  initial release
// ============================================================================
module regbank_write_sequencer
  import regbank_pkg::*;
#(
  parameter int DATA_W   = RB_DATA_W,
  parameter int SEL_W    = RB_SEL_W,
  parameter int NUM_GP   = RB_NUM_GP,
  parameter int PO0_ADDR = RB_PO0_ADDR,
  parameter int PO1_ADDR = RB_PO1_ADDR,
  parameter int W_ADDR   = RB_W_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_start,
  input  logic              dbg_valid,
  input  logic [SEL_W-1:0]  dbg_sel,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  input  logic              alu_valid,
  input  logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              wr_en,
  output logic [SEL_W-1:0]  wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              err_illegal,
  output logic [SEL_W-1:0]  err_sel,
  output logic [15:0]       wr_count
);

  // Sweep covers the GP block plus PO0, PO1 and W: NUM_GP + 3 writes.
  localparam int               IDX_W    = $clog2(NUM_GP + 3);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GP + 2);
  localparam logic [SEL_W-1:0] GP_LIMIT = SEL_W'(NUM_GP);
  localparam logic [SEL_W-1:0] PO0_SEL  = SEL_W'(PO0_ADDR);
  localparam logic [SEL_W-1:0] PO1_SEL  = SEL_W'(PO1_ADDR);
  localparam logic [SEL_W-1:0] W_SEL    = SEL_W'(W_ADDR);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [SEL_W-1:0]   sweep_sel;
  logic               accept;
  logic               arb_en;
  logic [1:0]         grant;
  logic               xfer;
  logic [SEL_W-1:0]   xfer_sel;
  logic [DATA_W-1:0]  xfer_data;
  logic               xfer_legal;

  // --------------------------------------------------------------------------
  // Request side: nothing is accepted while sweeping or in the cycle that
  // init_start restarts the sweep.
  // --------------------------------------------------------------------------
  assign accept    = (state == RUN) && !init_start;
  assign dbg_ready = accept && dbg_valid;
  assign arb_en    = accept && !dbg_valid;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({mem_valid, alu_valid}),
    .grant (grant)
  );

  assign alu_ready = grant[0];
  assign mem_ready = grant[1];

  always_comb begin
    xfer      = 1'b0;
    xfer_sel  = alu_sel;
    xfer_data = alu_data;
    if (dbg_ready) begin
      xfer      = 1'b1;
      xfer_sel  = dbg_sel;
      xfer_data = dbg_data;
    end else if (alu_ready) begin
      xfer      = 1'b1;
    end else if (mem_ready) begin
      xfer      = 1'b1;
      xfer_sel  = W_SEL;
      xfer_data = mem_data;
    end
  end

  assign xfer_legal = (xfer_sel < GP_LIMIT) || (xfer_sel == PO0_SEL)
                   || (xfer_sel == PO1_SEL) || (xfer_sel == W_SEL);

  // Sweep index -> bank address: 0..NUM_GP-1, then PO0, PO1, W.
  always_comb begin
    if (idx < IDX_W'(NUM_GP)) begin
      sweep_sel = SEL_W'(idx);
    end else if (idx == IDX_W'(NUM_GP)) begin
      sweep_sel = PO0_SEL;
    end else if (idx == IDX_W'(NUM_GP + 1)) begin
      sweep_sel = PO1_SEL;
    end else begin
      sweep_sel = W_SEL;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      idx         <= '0;
      wr_en       <= 1'b0;
      wr_sel      <= '0;
      wr_data     <= '0;
      busy        <= 1'b1;
      err_illegal <= 1'b0;
      err_sel     <= '0;
      wr_count    <= '0;
    end else begin
      wr_en       <= 1'b0;
      err_illegal <= 1'b0;
      // busy stays up through the cycle showing the last sweep write and
      // rises together with the restart when init_start hits in RUN.
      busy        <= (state == CLEAR) || init_start;

      case (state)
        CLEAR: begin
          if (init_start) begin
            idx      <= '0;
            wr_count <= '0;
          end else begin
            wr_en   <= 1'b1;
            wr_sel  <= sweep_sel;
            wr_data <= '0;
            if (idx == LAST_IDX) begin
              state <= RUN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        RUN: begin
          if (init_start) begin
            state    <= CLEAR;
            idx      <= '0;
            wr_count <= '0;
          end else if (xfer) begin
            if (xfer_legal) begin
              wr_en   <= 1'b1;
              wr_sel  <= xfer_sel;
              wr_data <= xfer_data;
              if (wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
              end
            end else begin
              // Request is consumed but never reaches the bank.
              err_illegal <= 1'b1;
              err_sel     <= xfer_sel;
            end
          end
        end

        default: begin
          state <= CLEAR;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regbank_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_write_sequencer
//  Purpose  : Self-checking bench for regbank_write_sequencer: clear sweep,
//             arbitration table, illegal-address handling, init/reset
//             restarts and counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regbank_write_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_start;
  logic        dbg_valid;
  logic [5:0]  dbg_sel;
  logic [15:0] dbg_data;
  logic        dbg_ready;
  logic        alu_valid;
  logic [5:0]  alu_sel;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        wr_en;
  logic [5:0]  wr_sel;
  logic [15:0] wr_data;
  logic        busy;
  logic        err_illegal;
  logic [5:0]  err_sel;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regbank_write_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .init_start  (init_start),
    .dbg_valid   (dbg_valid),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .dbg_ready   (dbg_ready),
    .alu_valid   (alu_valid),
    .alu_sel     (alu_sel),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .busy        (busy),
    .err_illegal (err_illegal),
    .err_sel     (err_sel),
    .wr_count    (wr_count)
  );

  typedef struct {
    logic        dv;
    logic [5:0]  ds;
    logic [15:0] dd;
    logic        av;
    logic [5:0]  asel;
    logic [15:0] ad;
    logic        mv;
    logic [15:0] md;
    logic [2:0]  rdy;   // {dbg, alu, mem} expected readies
    logic        en;
    logic [5:0]  sel;
    logic [15:0] data;
    logic        err;
    logic [5:0]  esel;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_sweep_sel(input int k);
    if (k < 28) return 6'(k);
    if (k == 28) return 6'd30;
    if (k == 29) return 6'd31;
    return 6'd34;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init_start = 1'b0;
    dbg_valid  = 1'b0; dbg_sel = '0; dbg_data = '0;
    alu_valid  = 1'b0; alu_sel = '0; alu_data = '0;
    mem_valid  = 1'b0; mem_data = '0;
  endtask

  // Waits (bounded) for the first sweep write, then checks all 31 writes,
  // then the drop of busy once the sweep is over.
  task automatic sweep_check(input string tag);
    int waits = 0;
    while (!wr_en && waits < 4) begin
      waits++;
      tick();
    end
    for (int k = 0; k < 31; k++) begin
      if (k > 0) tick();
      chk({tag, " sweep wr_en"}, 32'(wr_en), 32'd1);
      chk({tag, " sweep wr_sel"}, 32'(wr_sel), 32'(exp_sweep_sel(k)));
      chk({tag, " sweep wr_data"}, 32'(wr_data), 32'd0);
      chk({tag, " sweep busy"}, 32'(busy), 32'd1);
      if (k < 30)
        chk({tag, " sweep readies"}, 32'({dbg_ready, alu_ready, mem_ready}), 32'd0);
    end
    idle_inputs();
    tick();
    chk({tag, " busy after sweep"}, 32'(busy), 32'd0);
    chk({tag, " wr_en after sweep"}, 32'(wr_en), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           dv  ds     dd        av  asel   ad        mv  md        rdy     en  sel    data      err esel   cnt
    tbl[0]  = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd5,  16'h1234, 1'b1, 16'hBEEF, 3'b010, 1'b1, 6'd5,  16'h1234, 1'b0, 6'd0,  16'd1};
    tbl[1]  = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd5,  16'h1234, 1'b1, 16'hBEEF, 3'b001, 1'b1, 6'd34, 16'hBEEF, 1'b0, 6'd0,  16'd2};
    tbl[2]  = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd5,  16'h1234, 1'b1, 16'hBEEF, 3'b010, 1'b1, 6'd5,  16'h1234, 1'b0, 6'd0,  16'd3};
    tbl[3]  = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd5,  16'h1234, 1'b1, 16'hBEEF, 3'b001, 1'b1, 6'd34, 16'hBEEF, 1'b0, 6'd0,  16'd4};
    tbl[4]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h0000, 3'b000, 1'b0, 6'd34, 16'hBEEF, 1'b0, 6'd0,  16'd4};
    tbl[5]  = '{1'b1, 6'd30, 16'hA5A5, 1'b1, 6'd7,  16'h1111, 1'b1, 16'h2222, 3'b100, 1'b1, 6'd30, 16'hA5A5, 1'b0, 6'd0,  16'd5};
    tbl[6]  = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd7,  16'h1111, 1'b1, 16'h2222, 3'b010, 1'b1, 6'd7,  16'h1111, 1'b0, 6'd0,  16'd6};
    tbl[7]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h2222, 3'b001, 1'b1, 6'd34, 16'h2222, 1'b0, 6'd0,  16'd7};
    tbl[8]  = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd28, 16'h5555, 1'b0, 16'h0000, 3'b010, 1'b0, 6'd34, 16'h2222, 1'b1, 6'd28, 16'd7};
    tbl[9]  = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd35, 16'h6666, 1'b0, 16'h0000, 3'b010, 1'b0, 6'd34, 16'h2222, 1'b1, 6'd35, 16'd7};
    tbl[10] = '{1'b1, 6'd33, 16'h7777, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h0000, 3'b100, 1'b0, 6'd34, 16'h2222, 1'b1, 6'd33, 16'd7};
    tbl[11] = '{1'b1, 6'd0,  16'h0042, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h0000, 3'b100, 1'b1, 6'd0,  16'h0042, 1'b0, 6'd33, 16'd8};
    tbl[12] = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b1, 16'h9999, 3'b001, 1'b1, 6'd34, 16'h9999, 1'b0, 6'd33, 16'd9};
    tbl[13] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd27, 16'hABCD, 1'b1, 16'h1357, 3'b010, 1'b1, 6'd27, 16'hABCD, 1'b0, 6'd33, 16'd10};
    tbl[14] = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h0000, 3'b000, 1'b0, 6'd27, 16'hABCD, 1'b0, 6'd33, 16'd10};

    // ---------------- reset and initial sweep ----------------
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    chk("reset wr_en", 32'(wr_en), 32'd0);
    chk("reset wr_sel", 32'(wr_sel), 32'd0);
    chk("reset wr_data", 32'(wr_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset err_illegal", 32'(err_illegal), 32'd0);
    chk("reset err_sel", 32'(err_sel), 32'd0);
    chk("reset wr_count", 32'(wr_count), 32'd0);
    // Requests pending during the sweep must not be granted.
    dbg_valid = 1'b1; dbg_sel = 6'd1;
    alu_valid = 1'b1; alu_sel = 6'd2;
    mem_valid = 1'b1;
    reset = 1'b0;
    sweep_check("reset");

    // ---------------- arbitration / illegal table ----------------
    for (int i = 0; i < 15; i++) begin
      dbg_valid = tbl[i].dv; dbg_sel = tbl[i].ds; dbg_data = tbl[i].dd;
      alu_valid = tbl[i].av; alu_sel = tbl[i].asel; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_data = tbl[i].md;
      #1;
      chk($sformatf("vec%0d readies", i), 32'({dbg_ready, alu_ready, mem_ready}), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d wr_sel", i), 32'(wr_sel), 32'(tbl[i].sel));
      chk($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(tbl[i].data));
      chk($sformatf("vec%0d err_illegal", i), 32'(err_illegal), 32'(tbl[i].err));
      chk($sformatf("vec%0d err_sel", i), 32'(err_sel), 32'(tbl[i].esel));
      chk($sformatf("vec%0d wr_count", i), 32'(wr_count), 32'(tbl[i].cnt));
    end
    idle_inputs();

    // ---------------- init_start in RUN ----------------
    alu_valid = 1'b1; alu_sel = 6'd2; alu_data = 16'h0BAD;
    #1;
    chk("pre-init alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_sel = 6'd3; alu_data = 16'h0C0C;
    init_start = 1'b1;
    #1;
    chk("init alu_ready blocked", 32'(alu_ready), 32'd0);
    chk("init pending write en", 32'(wr_en), 32'd1);
    chk("init pending write sel", 32'(wr_sel), 32'd2);
    chk("init pending write data", 32'(wr_data), 32'h0BAD);
    chk("init pending count", 32'(wr_count), 32'd11);
    tick();
    idle_inputs();
    chk("init wr_en", 32'(wr_en), 32'd0);
    chk("init wr_count", 32'(wr_count), 32'd0);
    chk("init busy", 32'(busy), 32'd1);

    // ---------------- init_start during CLEAR at index 10 ----------------
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("partial sweep sel", 32'(wr_sel), 32'(exp_sweep_sel(k)));
    end
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    chk("clear-init wr_count", 32'(wr_count), 32'd0);
    sweep_check("init_clear");

    // ---------------- reset mid-sweep ----------------
    alu_valid = 1'b1; alu_sel = 6'd4; alu_data = 16'h4444;
    tick();
    idle_inputs();
    chk("pre-reset count", 32'(wr_count), 32'd1);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("mid reset wr_en", 32'(wr_en), 32'd0);
    chk("mid reset wr_count", 32'(wr_count), 32'd0);
    chk("mid reset busy", 32'(busy), 32'd1);
    reset = 1'b0;
    sweep_check("reset_mid");

    // ---------------- wr_count saturation ----------------
    alu_valid = 1'b1; alu_sel = 6'd1;
    for (int i = 0; i < 65540; i++) begin
      alu_data = 16'(i);
      tick();
      if (i == 65533) chk("count before saturation", 32'(wr_count), 32'hFFFE);
      if (i == 65534) chk("count reaches max", 32'(wr_count), 32'hFFFF);
    end
    idle_inputs();
    chk("count saturated", 32'(wr_count), 32'hFFFF);
    chk("last sat write data", 32'(wr_data), 32'(16'(65539)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regbank_write_sequencer.md
Name: regbank_write_sequencer

Overview:
- Single-owner controller for the register bank write port.
- Arbitrates three write requesters onto one registered write port (wr_en/wr_sel/wr_data): ALU C-bus writeback, memory load into W, and debug/loader.
- Performs a synchronous clear sweep of all writable registers after reset or on demand. This replaces asynchronous/level-triggered clearing inside the bank.
- Filters writes to read-only addresses and reports them.

Parameters:
- DATA_W, 16, data width of all write paths
- SEL_W, 6, register select width
- NUM_GP, 28, general-purpose registers at addresses 0..NUM_GP-1
- PO0_ADDR, 30, output port 0 address
- PO1_ADDR, 31, output port 1 address
- W_ADDR, 34, working register address; fixed target of memory loads

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- init_start  in  1  pulse: restart clear sweep
- dbg_valid  in  1  debug write request
- dbg_sel  in  SEL_W  debug target address
- dbg_data  in  DATA_W  debug write data
- dbg_ready  out  1  debug request accepted this cycle
- alu_valid  in  1  ALU writeback request
- alu_sel  in  SEL_W  ALU target address (Sel_C)
- alu_data  in  DATA_W  ALU result (Data_C)
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  memory-read data valid (MR)
- mem_data  in  DATA_W  memory read data, written to W_ADDR
- mem_ready  out  1  memory request accepted this cycle
- wr_en  out  1  bank write strobe, one cycle per write
- wr_sel  out  SEL_W  bank write address
- wr_data  out  DATA_W  bank write data
- busy  out  1  high while clear sweep is active
- err_illegal  out  1  one-cycle pulse: accepted request targeted a non-writable address
- err_sel  out  SEL_W  address of the last illegal request
- wr_count  out  16  legal requester writes since reset/init, saturating

Behaviour:
- Writable set: 0..NUM_GP-1, PO0_ADDR, PO1_ADDR, W_ADDR. All other addresses are illegal: 28, 29 (input ports), 32, 33, 35..63.
- States: CLEAR, RUN.
- Reset:
  - state=CLEAR, sweep index=0
  - wr_en=0, wr_sel=0, wr_data=0, err_illegal=0, err_sel=0, wr_count=0
  - RR pointer favours ALU
  - busy=1 starting the first cycle after reset
- CLEAR:
  - All readies low.
  - Each cycle, the sweep issues one write of 0, in order 0..27, 30, 31, 34 (31 writes, wr_en continuously high).
  - After the write to 34 is issued, state goes to RUN. busy drops in the cycle after the last sweep write appears on wr_en.
- RUN arbitration (combinational ready, same cycle as valid):
  - dbg has fixed highest priority.
  - Among alu and mem, round-robin: the pointer flips to the other requester after each grant to either of them.
  - At most one ready is high per cycle. A ready is never high without its valid.
- Transfer = valid & ready. One-cycle latency: the accepted request appears on wr_en/wr_sel/wr_data at the next rising edge. Memory transfers use wr_sel=W_ADDR.
- Back-to-back transfers: one per cycle, no bubbles.
- Illegal transfer: still consumed (ready high). Next cycle wr_en=0, err_illegal=1, err_sel=sel. wr_count is unchanged.
- wr_count: increments by 1 per legal transfer and saturates at 0xFFFF. Sweep writes are not counted. Cleared by reset or init_start.
- wr_sel/wr_data hold their last value when wr_en=0.
- init_start in RUN: no transfer is accepted that cycle. Next cycle state=CLEAR, index=0. A write already registered from the previous cycle still completes.
- init_start during CLEAR: the sweep restarts at index 0.
- reset has priority over init_start and over everything else, including mid-sweep and mid-transfer.
- Requesters must hold valid and payload stable until ready.

Decomposition:
- Shared package regbank_pkg: SEL_W/DATA_W constants, address constants (GP range, PI0=28, PI1=29, PO0=30, PO1=31, W=34), state enum {CLEAR, RUN}, and function is_writable(sel).
- The same package is used by the register bank for decode.
- One sub-module: rr_arb2, a two-requester round-robin arbiter with pointer update on grant, used for alu/mem.

Test Plan:
- Reset release: wr_en high for 31 consecutive cycles with wr_data=0 and wr_sel sequence 0..27, 30, 31, 34; busy=1 throughout, 0 afterward; all readies 0 during the sweep.
- RUN, alu_valid and mem_valid held 4 cycles (alu_sel=5, alu_data=0x1234; mem_data=0xBEEF): writes alternate (5,0x1234), (34,0xBEEF), (5,...), (34,...); wr_count=4.
- dbg_valid, alu_valid and mem_valid all high: dbg granted first, then alu/mem alternate; dbg with sel=30, data=0xA5A5 produces wr_sel=30, wr_data=0xA5A5.
- alu_sel=28, then alu_sel=35: each request accepted; next cycle wr_en=0, err_illegal=1 with err_sel=28, then 35; wr_count unchanged.
- init_start asserted at sweep index 10: the next write is index 0; wr_count=0; reset asserted mid-sweep behaves identically.
- 65540 legal ALU writes: wr_count saturates at 0xFFFF.
